// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - shared types and helpers for the TMR recovery controller
package RS5_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    RESYNC  = 3'd2,
    RELEASE = 3'd3,
    FATAL   = 3'd4
  } tmr_rec_state_t;

  typedef logic [2:0] replica_mask_t;

  localparam int LOG_W = 16;

  function automatic logic [1:0] popcount3(replica_mask_t m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_if.sv
// rtl/tmr_recovery_ctrl_if.sv - fault inputs and recovery outputs of the TMR supervisor
interface tmr_recovery_ctrl_if #(
  parameter int CNT_W = 8
);
  import RS5_pkg::*;

  logic                      fault_a_i;
  logic                      fault_b_i;
  logic                      fault_c_i;
  logic                      system_fault_i;
  logic                      mem_busy_i;
  logic                      stall_o;
  logic                      resync_en_o;
  replica_mask_t             resync_sel_o;
  logic [2:0]                state_o;
  logic                      fatal_o;
  logic [CNT_W-1:0]          recovery_count_o;
  logic [2:0][LOG_W-1:0]     fault_total_o;

  modport master (
    output fault_a_i, fault_b_i, fault_c_i, system_fault_i, mem_busy_i,
    input  stall_o, resync_en_o, resync_sel_o, state_o, fatal_o,
           recovery_count_o, fault_total_o
  );

  modport slave (
    input  fault_a_i, fault_b_i, fault_c_i, system_fault_i, mem_busy_i,
    output stall_o, resync_en_o, resync_sel_o, state_o, fatal_o,
           recovery_count_o, fault_total_o
  );
endinterface

// File: rtl/tmr_fault_counter.sv
// rtl/tmr_fault_counter.sv - per-replica consecutive-fault counter; TMR_FAULT_LOG_EN adds a total counter
module tmr_fault_counter
  import RS5_pkg::*;
#(
  parameter int FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fault_i,
  input  logic             count_en,
  input  logic             clear,
  input  logic             log_en,
  output logic             hit_o,
  output logic [LOG_W-1:0] total_o
);
  localparam int CW = $clog2(FAULT_THRESH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      if (!fault_i)
        cnt <= '0;
      else if (cnt != CW'(FAULT_THRESH))
        cnt <= cnt + 1'b1;
    end
  end

  assign hit_o = (cnt == CW'(FAULT_THRESH));

`ifdef TMR_FAULT_LOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      total_o <= '0;
    else if (log_en && fault_i && (total_o != '1))
      total_o <= total_o + 1'b1;
  end
`else
  logic unused_log_en;
  assign unused_log_en = log_en;
  assign total_o       = '0;
`endif

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// rtl/tmr_recovery_ctrl.sv - TMR supervisor: stall, resync faulty replica, escalate to FATAL; TMR_FAULT_LOG_EN enables fault totals
module tmr_recovery_ctrl
  import RS5_pkg::*;
#(
  parameter int FAULT_THRESH  = 4,
  parameter int RESYNC_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  tmr_recovery_ctrl_if.slave  bus
);
  localparam int TW = $clog2(RESYNC_CYCLES + 1);

  tmr_rec_state_t        state, next_state;
  replica_mask_t         fault_vec, hit, sel;
  logic [TW-1:0]         timer;
  logic [2:0][LOG_W-1:0] totals;

  logic                  stall_d, resync_en_d, fatal_d;
  replica_mask_t         resync_sel_d;
  logic [CNT_W-1:0]      rec_cnt, rec_cnt_d;

  assign fault_vec = {bus.fault_c_i, bus.fault_b_i, bus.fault_a_i};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    tmr_fault_counter #(.FAULT_THRESH(FAULT_THRESH)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .fault_i  (fault_vec[i]),
      .count_en (state == IDLE),
      .clear    ((state == RELEASE) && sel[i]),
      .log_en   (state != FATAL),
      .hit_o    (hit[i]),
      .total_o  (totals[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (popcount3(hit) == 2'd1)
          next_state = DRAIN;
        else if (popcount3(hit) >= 2'd2)
          next_state = FATAL;
      end
      DRAIN:   if (!bus.mem_busy_i) next_state = RESYNC;
      RESYNC:  if (timer == TW'(RESYNC_CYCLES - 1)) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      FATAL:   next_state = FATAL;
      default: next_state = FATAL;
    endcase
    // Loss of majority overrides whatever recovery step is in progress.
    if (bus.system_fault_i)
      next_state = FATAL;
  end

  // Outputs are decoded from next_state and registered so they line up with the state register.
  always_comb begin
    stall_d      = (next_state != IDLE);
    resync_en_d  = (next_state == RESYNC);
    resync_sel_d = resync_en_d ? sel : '0;
    fatal_d      = (next_state == FATAL);
    rec_cnt_d    = rec_cnt;
    if ((next_state == RELEASE) && (rec_cnt != '1))
      rec_cnt_d = rec_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel   <= '0;
      timer <= '0;
    end else begin
      if ((state == IDLE) && (next_state == DRAIN))
        sel <= hit;
      timer <= (state == RESYNC) ? timer + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_o      <= 1'b0;
      bus.resync_en_o  <= 1'b0;
      bus.resync_sel_o <= '0;
      bus.fatal_o      <= 1'b0;
      rec_cnt          <= '0;
    end else begin
      bus.stall_o      <= stall_d;
      bus.resync_en_o  <= resync_en_d;
      bus.resync_sel_o <= resync_sel_d;
      bus.fatal_o      <= fatal_d;
      rec_cnt          <= rec_cnt_d;
    end
  end

  assign bus.recovery_count_o = rec_cnt;
  assign bus.state_o          = state;
  assign bus.fault_total_o    = totals;

endmodule
